lu_accum: RTL and testbench

Sequential accumulator stage wrapped around the 8-bit logic unit. It accepts commands (op, operand, load flag) over a valid/ready handshake. The accumulator drives the LU "a" input and the command operand drives "b". The LU result "y" is captured back into the accumulator, and the result is presented downstream over a second valid/ready handshake. This is the stage that feeds the LU and consumes its output, turning the combinational LU into a usable datapath element.

---
 rtl/lu_accum_pkg.sv | 23 ++
 rtl/lu_accum_if.sv | 31 +++
 rtl/lu_accum_core.sv | 25 ++
 rtl/lu_accum.sv | 96 +++++++++
 tb/tb_lu_accum.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lu_accum_pkg.sv
// Shared definitions for the LU accumulator stage: widths, op codes, FSM states.
package lu_accum_pkg;

  localparam int unsigned LU_WIDTH = 8;
  localparam int unsigned LU_CNT_W = 8;
  localparam int unsigned LU_OP_W  = 2;

  // LU operation codes, bit-compatible with the existing LU variants
  typedef enum logic [LU_OP_W-1:0] {
    LU_AND = 2'b00,
    LU_OR  = 2'b01,
    LU_XOR = 2'b10,
    LU_NOT = 2'b11
  } lu_op_e;

  // Accumulator stage sequencing
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } lu_state_e;

endpackage : lu_accum_pkg

// File: rtl/lu_accum_if.sv
// Command and result handshakes of the LU accumulator stage.
interface lu_accum_if #(
  parameter int unsigned WIDTH = 8
);

  // command channel
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_ld;
  logic [WIDTH-1:0] in_operand;

  // result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;

  // Command source / result sink
  modport master (
    output in_valid, in_op, in_ld, in_operand, out_ready,
    input  in_ready, out_valid, out_y, out_zero
  );

  // The accumulator stage itself
  modport slave (
    input  in_valid, in_op, in_ld, in_operand, out_ready,
    output in_ready, out_valid, out_y, out_zero
  );

endinterface : lu_accum_if

// File: rtl/lu_accum_core.sv
// Combinational 8-bit-style logic unit: y = a op b (NOT ignores b).
module lu_core
  import lu_accum_pkg::*;
#(
  parameter int unsigned WIDTH = LU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  lu_op_e           op_i,
  output logic [WIDTH-1:0] y_c
);

  // Bitwise operation select; no carries anywhere
  always_comb begin
    y_c = '0;
    case (op_i)
      LU_AND:  y_c = a_i & b_i;
      LU_OR:   y_c = a_i | b_i;
      LU_XOR:  y_c = a_i ^ b_i;
      LU_NOT:  y_c = ~a_i;
      default: y_c = '0;
    endcase
  end

endmodule : lu_core

// File: rtl/lu_accum.sv
// Accumulator stage around lu_core: accepts a command, executes it against the
// accumulator in one cycle, then holds the result until downstream takes it.
module lu_accum
  import lu_accum_pkg::*;
#(
  parameter int unsigned WIDTH = LU_WIDTH,
  parameter int unsigned CNT_W = LU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  lu_accum_if.slave        bus,
  output logic [CNT_W-1:0] op_cnt
);

  lu_state_e        state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] operand_q;
  lu_op_e           op_q;
  logic             ld_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_zero_q;

  logic [WIDTH-1:0] lu_y_c;
  logic [WIDTH-1:0] acc_d;

  // LU always sees the accumulator on a and the latched operand on b
  lu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i  (acc_q),
    .b_i  (operand_q),
    .op_i (op_q),
    .y_c  (lu_y_c)
  );

  // Load bypasses the LU entirely
  assign acc_d = ld_q ? operand_q : lu_y_c;

  // Sequencer, accumulator, counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      operand_q   <= '0;
      op_q        <= LU_AND;
      ld_q        <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= lu_op_e'(bus.in_op);
            ld_q       <= bus.in_ld;
            operand_q  <= bus.in_operand;
            in_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_q       <= acc_d;
          out_zero_q  <= (acc_d == '0);
          out_valid_q <= 1'b1;
          if (!ld_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // out_y mirrors the accumulator, which only moves in EXEC
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = acc_q;
  assign bus.out_zero  = out_zero_q;
  assign op_cnt        = cnt_q;

endmodule : lu_accum

// File: tb/tb_lu_accum.sv
// Self-checking bench for lu_accum: directed scenarios plus random commands
// compared against a plain accumulator model.
module tb_lu_accum;
  import lu_accum_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] op_cnt;

  lu_accum_if #(.WIDTH(W)) bus ();

  lu_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .op_cnt (op_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] acc_m;
  int           cnt_m;

  function automatic logic [W-1:0] lu_ref(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic ld, input logic [W-1:0] b);
    if (ld) acc_m = b;
    else begin
      acc_m = lu_ref(op, acc_m, b);
      cnt_m = (cnt_m + 1) % 256;
    end
  endtask

  // One full transaction; tok=0 if handshake timing deviates from accept/EXEC/RESP
  task automatic send(input logic [1:0] op, input logic ld, input logic [W-1:0] b,
                      output logic [W-1:0] y, output logic z, output logic [CW-1:0] cnt,
                      output logic tok);
    int waited;
    waited = 0;
    tok    = 1'b1;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_ld      = ld;
    bus.in_operand = b;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) tok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) tok = 1'b0;
    @(negedge clk);
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) tok = 1'b0;
    y   = bus.out_y;
    z   = bus.out_zero;
    cnt = op_cnt;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_m = '0;
    cnt_m = 0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_y !== 8'h00 ||
        bus.out_zero !== 1'b0 || op_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset: valid=%b ready=%b y=%h zero=%b cnt=%0d, expected 0 1 00 0 0",
               bus.out_valid, bus.in_ready, bus.out_y, bus.out_zero, op_cnt);
    end
  endtask

  task automatic test_directed();
    logic [1:0]    ops [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    logic          lds [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0]  bs  [4] = '{8'hF0, 8'hCC, 8'hC0, 8'h55};
    logic [W-1:0]  ey  [4] = '{8'hF0, 8'hC0, 8'h00, 8'hFF};
    logic          ez  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [CW-1:0] ec  [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
    logic [W-1:0]  y;
    logic          z, tok;
    logic [CW-1:0] c;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], lds[i], bs[i], y, z, c, tok);
      model_apply(ops[i], lds[i], bs[i]);
      vectors++;
      if (y !== ey[i] || z !== ez[i] || c !== ec[i] || tok !== 1'b1) begin
        miscompares++;
        $display("FAIL directed[%0d]: y=%h zero=%b cnt=%0d timing=%b, expected %h %b %0d 1",
                 i, y, z, c, tok, ey[i], ez[i], ec[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  y;
    logic          z, tok;
    logic [CW-1:0] c, c0;
    send(2'b00, 1'b1, 8'hF0, y, z, c, tok);
    model_apply(2'b00, 1'b1, 8'hF0);
    c0 = c;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 2'b01; bus.in_ld = 1'b0; bus.in_operand = 8'hCC;
    @(posedge clk);
    #1;
    // a new command is presented and held while the stage is busy
    bus.in_op = 2'b00; bus.in_operand = 8'h00;
    model_apply(2'b01, 1'b0, 8'hCC);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_y !== 8'hFC || bus.in_ready !== 1'b0 ||
          bus.out_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: valid=%b y=%h ready=%b zero=%b, expected 1 fc 0 0",
                 i, bus.out_valid, bus.out_y, bus.in_ready, bus.out_zero);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_apply(2'b00, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== acc_m || bus.out_zero !== 1'b1 ||
        op_cnt !== c0 + 8'd2) begin
      miscompares++;
      $display("FAIL backpressure_pending: valid=%b y=%h zero=%b cnt=%0d, expected 1 %h 1 %0d",
               bus.out_valid, bus.out_y, bus.out_zero, op_cnt, acc_m, c0 + 8'd2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0]  y, v;
    logic          z, tok;
    logic [CW-1:0] c;
    v = W'($urandom) | 8'h01;
    send(2'b00, 1'b1, v, y, z, c, tok);
    model_apply(2'b00, 1'b1, v);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 2'b10; bus.in_ld = 1'b0; bus.in_operand = 8'h0F;
    @(posedge clk);
    #1;
    bus.in_op = 2'b00; bus.in_operand = 8'h00;
    model_apply(2'b10, 1'b0, 8'h0F);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || op_cnt !== c || bus.out_y !== v) begin
      miscompares++;
      $display("FAIL busy_exec: valid=%b cnt=%0d y=%h, expected 0 %0d %h",
               bus.out_valid, op_cnt, bus.out_y, c, v);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== acc_m) begin
      miscompares++;
      $display("FAIL busy_resp: valid=%b y=%h, expected 1 %h", bus.out_valid, bus.out_y, acc_m);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_apply(2'b00, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== acc_m || op_cnt !== CW'(cnt_m)) begin
      miscompares++;
      $display("FAIL busy_release: valid=%b y=%h cnt=%0d, expected 1 %h %0d",
               bus.out_valid, bus.out_y, op_cnt, acc_m, cnt_m);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || op_cnt !== CW'(cnt_m)) begin
        miscompares++;
        $display("FAIL busy_once[%0d]: valid=%b ready=%b cnt=%0d, expected 0 1 %0d",
                 i, bus.out_valid, bus.in_ready, op_cnt, cnt_m);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]    op;
    logic          ld;
    logic [W-1:0]  b, y;
    logic          z, tok;
    logic [CW-1:0] c;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      ld = ($urandom_range(0, 4) == 0);
      b  = W'($urandom);
      send(op, ld, b, y, z, c, tok);
      model_apply(op, ld, b);
      vectors++;
      if (y !== acc_m || z !== (acc_m == '0) || c !== CW'(cnt_m) || tok !== 1'b1) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d ld=%b b=%h: y=%h zero=%b cnt=%0d timing=%b, expected %h %b %0d 1",
                 i, op, ld, b, y, z, c, tok, acc_m, (acc_m == '0), cnt_m);
      end
    end
  endtask

  task automatic test_counter_wrap();
    logic [W-1:0]  r, y;
    logic          z, tok;
    logic [CW-1:0] c, start;
    r = W'($urandom);
    send(2'b00, 1'b1, r, y, z, c, tok);
    model_apply(2'b00, 1'b1, r);
    start = c;
    for (int i = 0; i < 256; i++) begin
      send(2'b10, 1'b0, 8'h00, y, z, c, tok);
      model_apply(2'b10, 1'b0, 8'h00);
      vectors++;
      if (y !== r || c !== CW'(cnt_m) || tok !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_xor[%0d]: y=%h cnt=%0d timing=%b, expected %h %0d 1",
                 i, y, c, tok, r, cnt_m);
      end
      if (i % 64 == 10) begin
        send(2'b01, 1'b1, r, y, z, c, tok);
        model_apply(2'b01, 1'b1, r);
        vectors++;
        if (y !== r || c !== CW'(cnt_m)) begin
          miscompares++;
          $display("FAIL wrap_load[%0d]: y=%h cnt=%0d, expected %h %0d", i, y, c, r, cnt_m);
        end
      end
    end
    vectors++;
    if (op_cnt !== start || bus.out_y !== r) begin
      miscompares++;
      $display("FAIL wrap_final: cnt=%0d y=%h, expected %0d %h", op_cnt, bus.out_y, start, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0]  y;
    logic          z, tok;
    logic [CW-1:0] c;
    send(2'b00, 1'b1, 8'hF0, y, z, c, tok);
    model_apply(2'b00, 1'b1, 8'hF0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 2'b00; bus.in_ld = 1'b0; bus.in_operand = 8'hCC;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_m = '0;
    cnt_m = 0;
    vectors++;
    if (bus.out_y !== 8'h00 || op_cnt !== 8'h00 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1 || bus.out_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: y=%h cnt=%0d valid=%b ready=%b zero=%b, expected 00 0 0 1 0",
               bus.out_y, op_cnt, bus.out_valid, bus.in_ready, bus.out_zero);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_noresult[%0d]: valid=%b, expected 0", i, bus.out_valid);
      end
    end
    send(2'b01, 1'b0, 8'h0A, y, z, c, tok);
    model_apply(2'b01, 1'b0, 8'h0A);
    vectors++;
    if (y !== 8'h0A || c !== 8'd1 || tok !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_after: y=%h cnt=%0d timing=%b, expected 0a 1 1", y, c, tok);
    end
  endtask

  // Run bound: a stalled design must still end the run
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, expected completion before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_op      = 2'b00;
    bus.in_ld      = 1'b0;
    bus.in_operand = '0;
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    acc_m          = '0;
    cnt_m          = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_ignore();
    test_random();
    test_counter_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_lu_accum
